// File: rtl/perip_bus_pkg.sv
// rtl/perip_bus_pkg.sv - shared size codes, FSM states and peripheral address map for the bus master
package perip_bus_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_t;

    localparam logic [31:0] PERIP_MASK     = 32'hffff_0030;
    localparam logic [31:0] PERIP_OFS_DATA = 32'h0000_0000;
    localparam logic [31:0] PERIP_OFS_TINT = 32'h0000_0004;
    localparam logic [31:0] PERIP_OFS_CTRL = 32'h0000_0008;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/perip_lane_align.sv
// rtl/perip_lane_align.sv - byte/half lane extraction with extension, and sub-word merge for RMW stores
module perip_lane_align
    import perip_bus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v     = addr_lo[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;
        case (size)
            SZ_B: begin
                load_data  = {{24{is_signed & byte_v[7]}}, byte_v};
                store_word = word;
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                load_data  = {{16{is_signed & half_v[15]}}, half_v};
                store_word = word;
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/perip_bus_master.sv
// rtl/perip_bus_master.sv - LSU-to-peripheral-bus initiator with RMW sub-word stores
// Define PERIP_MASTER_POSTED_WR_EN to respond to stores during the WR cycle (posted writes).
module perip_bus_master
    import perip_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_t            state;
    logic [1:0]        addr_lo_r;
    logic [1:0]        size_r;
    logic              sgn_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic [1:0]        req_sz;
    logic [ADDR_W-1:0] req_waddr;

    // Size 3 is folded into word so every downstream decision sees only B/H/W.
    assign req_sz    = (req_size == 2'd3) ? SZ_W : req_size;
    assign req_waddr = {req_addr[ADDR_W-1:2], 2'b00};

    // Driven only from the registered mem_we, so the bus is released the same edge it drops.
    assign mem_data = mem_we ? mem_dout : {DATA_W{1'bz}};

    perip_lane_align u_lane_align (
        .word       (mem_data),
        .addr_lo    (addr_lo_r),
        .size       (size_r),
        .is_signed  (sgn_r),
        .wdata      (wdata_r),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            addr_lo_r  <= 2'b00;
            size_r     <= SZ_B;
            sgn_r      <= 1'b0;
            wdata_r    <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        addr_lo_r <= req_addr[1:0];
                        size_r    <= req_sz;
                        sgn_r     <= req_signed;
                        wdata_r   <= req_wdata;
                        if (is_misaligned(req_sz, req_addr[1:0])) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_we) begin
                            state    <= ST_RD;
                            mem_addr <= req_waddr;
                        end else if (req_sz == SZ_W) begin
                            state    <= ST_WR;
                            mem_we   <= 1'b1;
                            mem_addr <= req_waddr;
                            mem_dout <= req_wdata;
`ifdef PERIP_MASTER_POSTED_WR_EN
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
`endif
                        end else begin
                            state    <= ST_RMW_RD;
                            mem_addr <= req_waddr;
                        end
                    end
                end
                ST_RD: begin
                    state      <= ST_RESP;
                    mem_addr   <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                end
                ST_RMW_RD: begin
                    state    <= ST_WR;
                    mem_we   <= 1'b1;
                    mem_dout <= store_word;
`ifdef PERIP_MASTER_POSTED_WR_EN
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
`endif
                end
                ST_WR: begin
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
`ifdef PERIP_MASTER_POSTED_WR_EN
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
`else
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
`endif
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/perip_bus_master.md
Name: perip_bus_master

Overview:
- Initiator side of the embedded-SoC peripheral bus: mem_we, mem_addr, and a shared tri-state mem_data.
- Accepts load/store requests from the core's LSU over a valid/ready handshake and converts each into word-wide bus cycles.
- The bus has no byte strobes, so sub-word stores are done as read-modify-write (RMW).
- Returns sign- or zero-extended load data and an error flag for misaligned accesses.
- Sits between the core and all memory-mapped peripherals (timer, gpio, uart).

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width; only 32 is supported.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- req_signed  in  1  sign-extend load result.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned access; qualified by resp_valid.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned bus address.
- mem_data  inout  32  driven by this block only while mem_we=1, else high-Z.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_addr=0, mem_data released (Z).
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - Handshake occurs on req_valid&req_ready; all req_* fields are captured at that edge.
- Misalignment check at accept: half with addr[0]=1, or word with addr[1:0]!=0.
  - Go to RESP with err=1. No bus cycle is issued.
- Otherwise, next state:
  - load -> RD.
  - word store -> WR.
  - byte/half store -> RMW_RD.
- RD:
  - mem_we=0, mem_addr={addr[31:2],2'b00} for exactly one cycle.
  - mem_data is sampled at the closing edge (peripheral read is combinational).
  - Lane extraction by addr[1:0]: byte lane = addr[1:0], half lane = addr[1].
  - Extend per req_signed, then go to RESP.
- RMW_RD:
  - Same bus drive as RD.
  - Sampled word is merged with req_wdata into the selected lane(s); go to WR.
- WR:
  - mem_we=1, mem_addr=word address, mem_data=merged word for one cycle; peripheral latches at the closing edge.
  - Then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; then go to IDLE.
  - req_ready=0 in every non-IDLE state.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - misaligned: 1 cycle.
- Back-to-back: the next accept is possible in the cycle after RESP; throughput is one access per 3 cycles minimum.
- Bus idle (IDLE/RESP): mem_we=0, mem_addr=0, mem_data=Z.
- Timing and contention rules:
  - mem_we and mem_data are registered outputs, glitch-free.
  - No overlap: mem_data is never driven in the same cycle a peripheral drives it (peripherals only drive while mem_we=0).
- Mid-operation reset: abort immediately.
  - A partial RMW leaves the target unwritten.
  - No resp_valid is generated.
- req_size=3 behaves exactly as size 2.

Optional Feature:
- Macro PERIP_MASTER_POSTED_WR_EN.
- Defined:
  - Stores raise resp_valid (err=0, rdata=0) during the WR cycle itself.
  - Go straight to IDLE, skipping RESP; store latency drops by 1 cycle.
  - Loads and misaligned accesses are unchanged.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared package perip_bus_pkg holds:
  - size codes (SZ_B/SZ_H/SZ_W) and state encoding;
  - peripheral address constants: PERIP_MASK 0xffff0030, offsets DATA/TINT/CTRL = 0x0/0x4/0x8.
- One combinational sub-module, perip_lane_align:
  - inputs: word, addr[1:0], size, signed, wdata;
  - outputs: extracted/extended load data and merged store word.

Test Plan:
- Word store 0x0000_0064 to 0xffff0034, then word load 0xffff0034:
  - WR cycle shows mem_we=1, mem_addr=0xffff0034, mem_data=0x64;
  - load resp_rdata=0x64, err=0, resp_valid 2 cycles after accept.
- Byte store 0xAB to 0xffff0039 after CTRL holds 0x0000_0003:
  - RMW_RD reads 0x3, WR drives 0x0000_AB03;
  - resp_valid 3 cycles after accept.
- Signed byte load at addr[1:0]=1 with bus word 0x0000_8000 -> resp_rdata=0xFFFF_FF80.
- Unsigned half load at addr[1]=1 with bus word 0x8001_0000 -> resp_rdata=0x0000_8001.
- Half load at 0xffff0031 -> resp_err=1 one cycle after accept; mem_we stays 0 and mem_addr stays 0 throughout.
- Reset asserted during the RMW_RD of a byte store:
  - mem_we stays 0 and mem_data returns to Z asynchronously;
  - no resp_valid;
  - after release, req_ready=1 and target register unchanged.
